// File: rtl/mini_alu_pipe_if.sv
// mini_alu_pipe_if: bus between the mini_alu_pipe core and its board top.
//   iEnable      1=pipeline advances, 0=everything holds
//   iInstruction instruction word at oIP, {op[3:0], dst, src1, src0}
//   oIP          fetch address
//   oLed         LED register
//   oLedStrobe   one-cycle pulse when oLed updates
//   oHalted      high after HLT executes, until reset
//   oDbgState    core run/halt state (0=run, 1=halt), for checkers
// Handshake: there is no valid/ready pair. iInstruction must be valid in the
// same cycle as oIP; it is captured on every rising edge where iEnable=1.
// master = board/bench side, slave = core side.
interface mini_alu_pipe_if #(
   parameter int FIELD_WIDTH = 8,
   parameter int LED_WIDTH   = 8
);
   logic                       iEnable;
   logic [4+3*FIELD_WIDTH-1:0] iInstruction;
   logic [FIELD_WIDTH-1:0]     oIP;
   logic [LED_WIDTH-1:0]       oLed;
   logic                       oLedStrobe;
   logic                       oHalted;
   logic                       oDbgState;

   modport master (
      output iEnable, iInstruction,
      input  oIP, oLed, oLedStrobe, oHalted, oDbgState
   );
   modport slave (
      input  iEnable, iInstruction,
      output oIP, oLed, oLedStrobe, oHalted, oDbgState
   );
endinterface

// File: rtl/mini_alu_pipe.sv
// mini_alu_pipe: 3-stage (Fetch / Execute / Writeback) ALU core with an
// internal register file, W->X forwarding, branch squash and HALT.
//   Clock  rising-edge clock
//   Reset  asynchronous active-low reset, clears all state
//   bus    mini_alu_pipe_if.slave (enable, instruction in; IP, LED, status out)
module mini_alu_pipe #(
   parameter int DATA_WIDTH  = 16,
   parameter int FIELD_WIDTH = 8,
   parameter int REG_AW      = 4,
   parameter int LED_WIDTH   = 8
) (
   input logic             Clock,
   input logic             Reset,
   mini_alu_pipe_if.slave  bus
);
   localparam int IW = 4 + 3*FIELD_WIDTH;

   localparam logic [3:0] OP_LED = 4'd1, OP_BLE = 4'd2, OP_STO = 4'd3,
                          OP_ADD = 4'd4, OP_JMP = 4'd5, OP_SUB = 4'd6,
                          OP_AND = 4'd7, OP_OR  = 4'd8, OP_SHL = 4'd9,
                          OP_SHR = 4'd10, OP_HLT = 4'd11;

   typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

   state_t                 state_q;
   logic [FIELD_WIDTH-1:0] ip_q;
   logic                   x_valid_q;
   logic [IW-1:0]          x_instr_q;
   logic                   w_valid_q;
   logic [REG_AW-1:0]      w_dst_q;
   logic [DATA_WIDTH-1:0]  w_data_q;
   logic [DATA_WIDTH-1:0]  rf_q [2**REG_AW];
   logic [LED_WIDTH-1:0]   led_q;
   logic                   strobe_q;

   // X-stage decode
   logic [3:0]             x_op;
   logic [FIELD_WIDTH-1:0] x_dst, x_s1, x_s0;
   logic [REG_AW-1:0]      s1_idx, s0_idx;
   logic [DATA_WIDTH-1:0]  opa, opb, imm, res_d;
   logic [DATA_WIDTH+2*FIELD_WIDTH-1:0] imm_ext;
   logic                   wen_d, taken_d, led_d, halt_d;

   assign {x_op, x_dst, x_s1, x_s0} = x_instr_q;
   assign s1_idx = x_s1[REG_AW-1:0];
   assign s0_idx = x_s0[REG_AW-1:0];

   // The W result has not reached the register file yet; take it directly.
   assign opa = (w_valid_q && w_dst_q == s1_idx) ? w_data_q : rf_q[s1_idx];
   assign opb = (w_valid_q && w_dst_q == s0_idx) ? w_data_q : rf_q[s0_idx];

   // Zero-extend then truncate so any DATA_WIDTH vs 2*FIELD_WIDTH works.
   assign imm_ext = {{DATA_WIDTH{1'b0}}, x_s1, x_s0};
   assign imm     = imm_ext[DATA_WIDTH-1:0];

   always_comb begin
      res_d   = '0;
      wen_d   = 1'b0;
      taken_d = 1'b0;
      led_d   = 1'b0;
      halt_d  = 1'b0;
      if (x_valid_q) begin
         case (x_op)
            OP_LED: led_d   = 1'b1;
            OP_BLE: taken_d = (opa <= opb);
            OP_JMP: taken_d = 1'b1;
            OP_HLT: halt_d  = 1'b1;
            OP_STO: begin wen_d = 1'b1; res_d = imm;         end
            OP_ADD: begin wen_d = 1'b1; res_d = opa + opb;   end
            OP_SUB: begin wen_d = 1'b1; res_d = opa - opb;   end
            OP_AND: begin wen_d = 1'b1; res_d = opa & opb;   end
            OP_OR:  begin wen_d = 1'b1; res_d = opa | opb;   end
            OP_SHL: begin wen_d = 1'b1; res_d = opa << opb[3:0]; end
            OP_SHR: begin wen_d = 1'b1; res_d = opa >> opb[3:0]; end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q   <= ST_RUN;
         ip_q      <= '0;
         x_valid_q <= 1'b0;
         x_instr_q <= '0;
         w_valid_q <= 1'b0;
         w_dst_q   <= '0;
         w_data_q  <= '0;
         led_q     <= '0;
         strobe_q  <= 1'b0;
         for (int i = 0; i < 2**REG_AW; i++) rf_q[i] <= '0;
      end else if (!bus.iEnable) begin
         // A strobe swallowed by a hold is dropped, not replayed on resume.
         strobe_q <= 1'b0;
      end else begin
         strobe_q <= led_d;
         if (led_d) led_q <= opa[LED_WIDTH-1:0];
         if (w_valid_q) rf_q[w_dst_q] <= w_data_q;
         w_valid_q <= wen_d;
         w_dst_q   <= x_dst[REG_AW-1:0];
         w_data_q  <= res_d;
         case (state_q)
            ST_RUN: begin
               if (halt_d) begin
                  state_q   <= ST_HALT;
                  x_valid_q <= 1'b0;
               end else if (taken_d) begin
                  // Squash the instruction fetched alongside the branch.
                  ip_q      <= x_dst;
                  x_valid_q <= 1'b0;
               end else begin
                  ip_q      <= ip_q + FIELD_WIDTH'(1);
                  x_valid_q <= 1'b1;
                  x_instr_q <= bus.iInstruction;
               end
            end
            ST_HALT: x_valid_q <= 1'b0;
            default: state_q <= ST_RUN;
         endcase
      end
   end

   assign bus.oIP        = ip_q;
   assign bus.oLed       = led_q;
   assign bus.oLedStrobe = strobe_q & bus.iEnable;
   assign bus.oHalted    = (state_q == ST_HALT);
   assign bus.oDbgState  = state_q;
endmodule

// File: tb/tb_mini_alu_pipe.sv
module tb_mini_alu_pipe;
   logic Clock = 1'b0;
   logic Reset = 1'b0;
   always #5 Clock = ~Clock;

   mini_alu_pipe_if bus ();
   mini_alu_pipe dut (.Clock(Clock), .Reset(Reset), .bus(bus));

   logic [27:0] imem [256];
   assign bus.iInstruction = imem[bus.oIP];

   int total = 0;
   int bad   = 0;

   // Instruction-level reference: expected outputs per enabled-edge count k.
   int mip  [1024];
   int mled [1024];
   int eled [1024];
   bit mstb [1024];
   bit mhalt[1024];

   function automatic logic [27:0] enc(input int op, input int d, input int s1, input int s0);
      logic [27:0] w;
      w = {op[3:0], d[7:0], s1[7:0], s0[7:0]};
      return w;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic build_model(input int nk);
      int r[16];
      int pc, k, op, d, s1, s0, a, b, led;
      bit taken;
      for (int i = 0; i < 1024; i++) begin
         mip[i] = 0; mled[i] = -1; mstb[i] = 0; mhalt[i] = 0;
      end
      for (int i = 0; i < 16; i++) r[i] = 0;
      pc = 0; k = 0; mip[0] = 0;
      while (k < nk) begin
         op = imem[pc][27:24]; d = imem[pc][23:16];
         s1 = imem[pc][15:8];  s0 = imem[pc][7:0];
         a = r[s1 % 16]; b = r[s0 % 16];
         taken = 0;
         mip[k+1] = (pc + 1) % 256;
         case (op)
            1: begin mled[k+2] = a % 256; mstb[k+2] = 1; end
            2: taken = (a <= b);
            3: r[d % 16] = s1 * 256 + s0;
            4: r[d % 16] = (a + b) % 65536;
            5: taken = 1;
            6: r[d % 16] = (a - b + 65536) % 65536;
            7: r[d % 16] = a & b;
            8: r[d % 16] = a | b;
            9: r[d % 16] = (a << (b % 16)) % 65536;
            10: r[d % 16] = a >> (b % 16);
            default: ;
         endcase
         if (op == 11) begin
            for (int j = k + 1; j < 1024; j++) mip[j] = (pc + 1) % 256;
            for (int j = k + 2; j < 1024; j++) mhalt[j] = 1;
            break;
         end else if (taken) begin
            mip[k+2] = d; pc = d; k += 2;
         end else begin
            pc = (pc + 1) % 256; k += 1;
         end
      end
      led = 0;
      for (int i = 0; i < 1024; i++) begin
         if (mled[i] >= 0) led = mled[i];
         eled[i] = led;
      end
   endtask

   // Called just after a posedge: asserts reset asynchronously and checks it.
   task automatic do_reset();
      Reset = 1'b0;
      bus.iEnable = 1'b1;
      #1;
      chk("rst_ip",   bus.oIP, 0);
      chk("rst_led",  bus.oLed, 0);
      chk("rst_stb",  bus.oLedStrobe, 0);
      chk("rst_halt", bus.oHalted, 0);
      @(posedge Clock); #1;
      Reset = 1'b1;
   endtask

   // mode 0: always enabled, 1: random holds, 2: hold for cycles 2..6
   task automatic run(input string name, input int ncyc, input int mode);
      int k;
      bit e, dis;
      k = 0; dis = 0;
      build_model(ncyc + 2);
      for (int c = 0; c < ncyc; c++) begin
         case (mode)
            1: e = ($urandom_range(0, 3) != 0);
            2: e = !(c >= 2 && c <= 6);
            default: e = 1'b1;
         endcase
         bus.iEnable = e;
         @(negedge Clock);
         chk({name, "_ip"},   bus.oIP, mip[k]);
         chk({name, "_led"},  bus.oLed, eled[k]);
         chk({name, "_stb"},  bus.oLedStrobe, (mstb[k] && e && !dis) ? 1 : 0);
         chk({name, "_halt"}, bus.oHalted, mhalt[k]);
         @(posedge Clock);
         if (e) begin k++; dis = 0; end else dis = 1;
         #1;
      end
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 256; i++) imem[i] = '0;
   endtask

   initial begin
      bus.iEnable = 1'b1;
      clear_imem();
      @(posedge Clock); #1;

      // Forwarding and ALU ops
      do_reset();
      imem[0]  = enc(3, 1, 0, 5);
      imem[1]  = enc(3, 2, 0, 3);
      imem[2]  = enc(4, 3, 2, 1);
      imem[3]  = enc(1, 0, 3, 0);
      imem[4]  = enc(6, 4, 2, 1);
      imem[5]  = enc(1, 0, 4, 0);
      imem[6]  = enc(9, 5, 1, 2);
      imem[7]  = enc(1, 0, 5, 0);
      imem[8]  = enc(3, 8, 8'h80, 0);
      imem[9]  = enc(3, 9, 0, 15);
      imem[10] = enc(10, 10, 8, 9);
      imem[11] = enc(1, 0, 10, 0);
      imem[12] = enc(11, 0, 0, 0);
      run("alu", 30, 0);
      chk("alu_final_led", bus.oLed, 8'h01);

      // BLE taken at 0x07, shadow STO R6 at 0x08 squashed
      do_reset();
      clear_imem();
      imem[0] = enc(3, 1, 0, 3);
      imem[1] = enc(3, 2, 0, 5);
      imem[7] = enc(2, 8'h20, 1, 2);
      imem[8] = enc(3, 6, 0, 9);
      imem[9] = enc(11, 0, 0, 0);
      imem[8'h20] = enc(1, 0, 6, 0);
      imem[8'h21] = enc(3, 6, 0, 7);
      imem[8'h22] = enc(1, 0, 6, 0);
      imem[8'h23] = enc(11, 0, 0, 0);
      run("ble_t", 40, 0);
      chk("ble_t_led", bus.oLed, 8'h07);

      // BLE not taken: 5 <= 3 false
      do_reset();
      imem[7] = enc(2, 8'h20, 2, 1);
      imem[9] = enc(1, 0, 6, 0);
      imem[10] = enc(11, 0, 0, 0);
      run("ble_n", 30, 0);
      chk("ble_n_led", bus.oLed, 8'h09);

      // Straight-line wrap, then JMP 0x00 at 0xFF
      do_reset();
      clear_imem();
      run("wrap", 300, 0);
      do_reset();
      imem[8'hFF] = enc(5, 0, 0, 0);
      run("jmpwrap", 300, 0);

      // ADD R7 then HLT; frozen; reset clears R7 (LED R7 at IP 0 reads 0)
      do_reset();
      clear_imem();
      imem[0] = enc(1, 0, 7, 0);
      imem[1] = enc(3, 1, 0, 5);
      imem[2] = enc(3, 2, 0, 7);
      imem[3] = enc(4, 7, 2, 1);
      imem[4] = enc(11, 0, 0, 0);
      imem[5] = enc(1, 0, 7, 0);
      run("halt", 32, 0);
      do_reset();
      imem[1] = enc(11, 0, 0, 0);
      run("post_rst", 10, 0);

      // Hold between STO R1,#1 and LED R1
      do_reset();
      clear_imem();
      imem[0] = enc(3, 1, 0, 1);
      imem[1] = enc(1, 0, 1, 0);
      imem[2] = enc(11, 0, 0, 0);
      run("hold", 16, 2);
      chk("hold_led", bus.oLed, 8'h01);

      // Random programs with random holds
      for (int p = 0; p < 4; p++) begin
         do_reset();
         for (int i = 0; i < 256; i++) begin
            int op;
            op = $urandom_range(0, 15);
            if (op == 11 && $urandom_range(0, 7) != 0) op = 4;
            imem[i] = enc(op, $urandom_range(0, 255), $urandom_range(0, 255),
                          $urandom_range(0, 255));
         end
         run("rand", 300, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
